// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default baud divisor and line idle level.
// Kept generic so the receive side can reuse the same encodings.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } uart_state_t;

  localparam int   DEFAULT_CLKS_PER_BIT = 16;
  localparam logic TX_IDLE              = 1'b1;

  // States in which the line carries a timed UART bit.
  function automatic logic is_bit_state(input uart_state_t s);
    return (s == S_START) || (s == S_DATA) || (s == S_PARITY) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// clr holds the count at zero so every bit period starts aligned to a state change.
module fifo_uart_tx_baud_cnt
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == TERMINAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter (8N1; 8E1 when FIFO_UART_TX_PARITY_EN is defined).
// Pulls one byte per frame from a registered-read fifo and serialises it LSB first.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  re,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  uart_state_t           state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IW-1:0]         bit_idx_reg;
  logic                  tx_reg;
  logic                  tx_done_reg;
  logic                  baud_tick;
  logic                  baud_clr;

  // Counter only runs while a bit is on the line, so it restarts on every state change.
  assign baud_clr = ~is_bit_state(state_reg);

  fifo_uart_tx_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(baud_tick)
  );

  assign re      = (state_reg == S_READ) & ~empty;
  assign busy    = (state_reg != S_IDLE);
  assign tx      = tx_reg;
  assign tx_done = tx_done_reg;

  // tx is loaded on the edge that enters each state, so the line is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= TX_IDLE;
      tx_done_reg <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          tx_reg <= TX_IDLE;
          if (!empty) state_reg <= S_READ;
        end
        S_READ: state_reg <= S_LOAD;
        S_LOAD: begin
          shift_reg   <= fifo_data;
          bit_idx_reg <= '0;
          tx_reg      <= 1'b0;
          state_reg   <= S_START;
        end
        S_START: begin
          if (baud_tick) begin
            tx_reg    <= shift_reg[0];
            state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_idx_reg == LAST_BIT) begin
              bit_idx_reg <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx_reg      <= ^shift_reg;
              state_reg   <= S_PARITY;
`else
              tx_reg      <= TX_IDLE;
              state_reg   <= S_STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + IW'(1);
              tx_reg      <= shift_reg[bit_idx_reg + IW'(1)];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            tx_reg    <= TX_IDLE;
            state_reg <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_tick) begin
            tx_done_reg <= 1'b1;
            tx_reg      <= TX_IDLE;
            state_reg   <= empty ? S_IDLE : S_READ;
          end
        end
        default: begin
          tx_reg    <= TX_IDLE;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural 8x16 registered-read fifo and
// a mid-bit UART monitor; parity cases run when FIFO_UART_TX_PARITY_EN is defined.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;
  localparam int GAP       = FRAME_CYC + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty, full, re, tx, busy, tx_done;
  logic [7:0] fifo_data = 8'h00;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .empty    (empty),
    .fifo_data(fifo_data),
    .re       (re),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  // Behavioural fifo: registered read, data valid the cycle after re.
  logic [7:0] mem [16];
  logic [3:0] wp = 4'd0, rp = 4'd0;
  logic [4:0] count = 5'd0;
  logic       we = 1'b0;
  logic [7:0] din = 8'h00;

  assign empty = (count == 5'd0);
  assign full  = (count == 5'd16);

  always @(posedge clk) begin
    if (we && !full) begin
      mem[wp] <= din;
      wp      <= wp + 4'd1;
    end
    if (re && !empty) begin
      fifo_data <= mem[rp];
      rp        <= rp + 4'd1;
    end
    count <= count + {4'd0, (we && !full)} - {4'd0, (re && !empty)};
  end

  int cyc = 0;
  int re_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (re) re_cnt <= re_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef FIFO_UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic write_byte(input logic [7:0] b, output int wr_cyc);
    din = b;
    we  = 1'b1;
    @(posedge clk);
    #1;
    wr_cyc = cyc;
    we = 1'b0;
  endtask

  // Waits for the start bit, samples every cycle of the frame, then checks tx_done.
  task automatic capture(output logic [10:0] bits, output int start_cyc);
    logic samples [FRAME_CYC];
    bit   seen, glitch, done_early;
    bits = '0;
    start_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("start_seen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    start_cyc  = cyc;
    samples[0] = tx;
    done_early = 1'b0;
    for (int i = 1; i < FRAME_CYC; i++) begin
      @(posedge clk);
      #1;
      samples[i] = tx;
      if (tx_done !== 1'b0) done_early = 1'b1;
    end
    glitch = 1'b0;
    for (int k = 0; k < FRAME_BITS; k++) begin
      bits[k] = samples[k*CPB + CPB/2];
      for (int j = 0; j < CPB; j++)
        if (samples[k*CPB + j] !== bits[k]) glitch = 1'b1;
    end
    check("bit_width", {31'd0, glitch}, 32'd0);
    check("tx_done_early", {31'd0, done_early}, 32'd0);
    @(posedge clk);
    #1;
    check("tx_done_pulse", {31'd0, tx_done}, 32'd1);
  endtask

  logic [7:0]  burst [16];
  logic [10:0] fr;
  int          wc, sc, prev_sc, re0;
  bit          bad_tx, bad_re, bad_busy, seen;

  initial begin
    burst = '{8'h11, 8'hF0, 8'h5A, 8'h80, 8'h01, 8'hFF, 8'h7E, 8'h3C,
              8'hC3, 8'h96, 8'h69, 8'h42, 8'hBD, 8'h0F, 8'hE7, 8'h24};

    // Reset and idle with empty fifo
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bad_tx = 0; bad_re = 0; bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) bad_tx = 1;
      if (re !== 1'b0) bad_re = 1;
      if (busy !== 1'b0) bad_busy = 1;
    end
    check("idle_tx", {31'd0, bad_tx}, 32'd0);
    check("idle_re", {31'd0, bad_re}, 32'd0);
    check("idle_busy", {31'd0, bad_busy}, 32'd0);

    // Single byte 0xA5
    re0 = re_cnt;
    write_byte(8'hA5, wc);
    capture(fr, sc);
    check("a5_latency", sc - wc, 32'd3);
    check("a5_frame", {21'd0, fr}, {21'd0, frame_of(8'hA5)});
`ifndef FIFO_UART_TX_PARITY_EN
    check("a5_waveform", {22'd0, fr[9:0]}, {22'd0, 10'b1101001010});
`endif
    @(posedge clk);
    #1;
    check("a5_done_one_cycle", {31'd0, tx_done}, 32'd0);
    check("a5_re_pulses", re_cnt - re0, 32'd1);
    check("a5_empty", {31'd0, empty}, 32'd1);
    check("a5_busy_idle", {31'd0, busy}, 32'd0);

    // Fill the fifo while held in reset, then drain 16 frames back to back
    rst = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(burst[i], wc);
    check("burst_full", {31'd0, full}, 32'd1);
    rst = 1'b0;
    re0 = re_cnt;
    prev_sc = 0;
    for (int i = 0; i < 16; i++) begin
      capture(fr, sc);
      check($sformatf("burst_frame_%0d", i), {21'd0, fr}, {21'd0, frame_of(burst[i])});
      if (i == 0) check("burst_full_clear", {31'd0, full}, 32'd0);
      else check($sformatf("burst_gap_%0d", i), sc - prev_sc, GAP);
      prev_sc = sc;
    end
    check("burst_re_pulses", re_cnt - re0, 32'd16);
    check("burst_empty", {31'd0, empty}, 32'd1);

    // Async reset in the middle of 0x3C's data bits; 0x5A follows cleanly
    re0 = re_cnt;
    write_byte(8'h3C, wc);
    write_byte(8'h5A, wc);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        seen = 1;
        break;
      end
    end
    check("abort_start_seen", {31'd0, seen}, 32'd1);
    repeat (CPB * 3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_tx_high", {31'd0, tx}, 32'd1);
    check("abort_busy_low", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    capture(fr, sc);
    check("after_abort_frame", {21'd0, fr}, {21'd0, frame_of(8'h5A)});
    check("abort_re_pulses", re_cnt - re0, 32'd2);
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) bad_tx = 1;
      if (busy !== 1'b0) bad_busy = 1;
    end
    check("no_resend_tx", {31'd0, bad_tx}, 32'd0);
    check("no_resend_busy", {31'd0, bad_busy}, 32'd0);

    // Write 0x00 while 0x81 is on the line
    re0 = re_cnt;
    write_byte(8'h81, wc);
    fork
      begin
        int wc2;
        repeat (15) @(posedge clk);
        #1;
        write_byte(8'h00, wc2);
      end
    join_none
    capture(fr, sc);
    check("inflight_frame", {21'd0, fr}, {21'd0, frame_of(8'h81)});
    check("inflight_no_early_re", re_cnt - re0, 32'd1);
    check("inflight_read_after_stop", {31'd0, re}, 32'd1);
    prev_sc = sc;
    capture(fr, sc);
    check("inflight_next_frame", {21'd0, fr}, {21'd0, frame_of(8'h00)});
    check("inflight_gap", sc - prev_sc, GAP);
    check("inflight_re_pulses", re_cnt - re0, 32'd2);

`ifdef FIFO_UART_TX_PARITY_EN
    write_byte(8'h07, wc);
    capture(fr, sc);
    check("parity_07_bit", {31'd0, fr[9]}, 32'd1);
    check("parity_07_frame", {21'd0, fr}, {21'd0, 11'b11000001110});
    write_byte(8'h03, wc);
    capture(fr, sc);
    check("parity_03_bit", {31'd0, fr[9]}, 32'd0);
    check("parity_03_frame", {21'd0, fr}, {21'd0, 11'b10000000110});
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
